// File: rtl/stream_pkg.sv
// Shared types and helpers for the packet stream blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_pkg;

    // Packet framing state: waiting for sop, accumulating, or waiting for eop
    // after the expected number of entries has already been taken.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Index width for a packet of 'length' entries, never narrower than 1 bit.
    function automatic int calc_awidth(input int length);
        int w;
        w = $clog2(length);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/packet_peak_detector.sv
// Per-packet peak detector: max, index of first max, exact sum and framing error.
// Latency: result registered, source_valid pulses one cycle after the terminating beat.
// Backpressure: none; every valid beat is accepted, results cannot be stalled.
//
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   sink_valid/sop/eop  : input framing, sop/eop qualified by sink_valid
//   sink_data           : signed input entry
//   source_valid        : one-cycle result pulse
//   source_max/argmax   : packet maximum and index of its first occurrence
//   source_sum          : exact signed packet sum
//   source_error        : length/framing error for the reported packet
//
// Build option PACKET_PEAK_DETECTOR_SUM_EN: when defined the sum accumulator is
// built; when undefined source_sum is tied to zero and no accumulator exists.
module packet_peak_detector
    import stream_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 1024,
    localparam int AWIDTH = calc_awidth(LENGTH),
    localparam int SWIDTH = WIDTH + AWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sink_valid,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [WIDTH-1:0]  sink_data,
    output logic              source_valid,
    output logic [WIDTH-1:0]  source_max,
    output logic [AWIDTH-1:0] source_argmax,
    output logic [SWIDTH-1:0] source_sum,
    output logic              source_error
);

    // Index of the last expected entry, one bit wider than the counter so the
    // incremented count can be compared without wrapping.
    localparam logic [AWIDTH:0] LAST_IDX   = (AWIDTH + 1)'(LENGTH - 1);
    // A packet that starts and ends on the same beat is only legal for LENGTH 1.
    localparam logic            SINGLE_ERR = (LENGTH != 1);

    // Accumulation state
    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]    max_q, max_d;
    logic [AWIDTH-1:0]   argmax_q, argmax_d;
    logic [AWIDTH:0]     cnt_inc;

    // Output register stage
    logic                out_vld_q, out_vld_d;
    logic [WIDTH-1:0]    out_max_q, out_max_d;
    logic [AWIDTH-1:0]   out_argmax_q, out_argmax_d;
    logic                out_err_q, out_err_d;

`ifdef PACKET_PEAK_DETECTOR_SUM_EN
    logic [SWIDTH-1:0]   sum_q, sum_d;
    logic [SWIDTH-1:0]   out_sum_q, out_sum_d;
    logic [SWIDTH-1:0]   data_sext;

    assign data_sext = {{AWIDTH{sink_data[WIDTH-1]}}, sink_data};
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        argmax_d     = argmax_q;
        out_vld_d    = 1'b0;
        out_max_d    = out_max_q;
        out_argmax_d = out_argmax_q;
        out_err_d    = out_err_q;
`ifdef PACKET_PEAK_DETECTOR_SUM_EN
        sum_d        = sum_q;
        out_sum_d    = out_sum_q;
`endif
        cnt_inc      = {1'b0, cnt_q} + (AWIDTH + 1)'(1);

        if (sink_valid) begin
            if (sink_sop) begin
                // A sop inside a packet closes the old one as malformed.
                if (state_q != IDLE) begin
                    out_vld_d    = 1'b1;
                    out_max_d    = max_q;
                    out_argmax_d = argmax_q;
                    out_err_d    = 1'b1;
`ifdef PACKET_PEAK_DETECTOR_SUM_EN
                    out_sum_d    = sum_q;
`endif
                end

                max_d    = sink_data;
                argmax_d = '0;
                cnt_d    = '0;
`ifdef PACKET_PEAK_DETECTOR_SUM_EN
                sum_d    = data_sext;
`endif

                if (sink_eop) begin
                    // Single-beat packet; overrides any aborted result above
                    // since only one result can be registered per cycle.
                    out_vld_d    = 1'b1;
                    out_max_d    = sink_data;
                    out_argmax_d = '0;
                    out_err_d    = SINGLE_ERR;
`ifdef PACKET_PEAK_DETECTOR_SUM_EN
                    out_sum_d    = data_sext;
`endif
                    state_d      = IDLE;
                end else begin
                    state_d      = BUSY;
                end
            end else begin
                unique case (state_q)
                    BUSY: begin
                        cnt_d = cnt_inc[AWIDTH-1:0];
                        // Strict compare keeps the earliest index on ties.
                        if ($signed(sink_data) > $signed(max_q)) begin
                            max_d    = sink_data;
                            argmax_d = cnt_inc[AWIDTH-1:0];
                        end
`ifdef PACKET_PEAK_DETECTOR_SUM_EN
                        sum_d = sum_q + data_sext;
`endif
                        if (sink_eop) begin
                            out_vld_d    = 1'b1;
                            out_max_d    = max_d;
                            out_argmax_d = argmax_d;
                            out_err_d    = (cnt_inc != LAST_IDX);
`ifdef PACKET_PEAK_DETECTOR_SUM_EN
                            out_sum_d    = sum_d;
`endif
                            state_d      = IDLE;
                        end else if (cnt_inc == LAST_IDX) begin
                            state_d      = DRAIN;
                        end
                    end
                    DRAIN: begin
                        // Excess entries are not part of the result.
                        if (sink_eop) begin
                            out_vld_d    = 1'b1;
                            out_max_d    = max_q;
                            out_argmax_d = argmax_q;
                            out_err_d    = 1'b1;
`ifdef PACKET_PEAK_DETECTOR_SUM_EN
                            out_sum_d    = sum_q;
`endif
                            state_d      = IDLE;
                        end
                    end
                    default: begin
                        // IDLE: beats without sop are dropped.
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            max_q        <= '0;
            argmax_q     <= '0;
            out_vld_q    <= 1'b0;
            out_max_q    <= '0;
            out_argmax_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            argmax_q     <= argmax_d;
            out_vld_q    <= out_vld_d;
            out_max_q    <= out_max_d;
            out_argmax_q <= out_argmax_d;
            out_err_q    <= out_err_d;
        end
    end

`ifdef PACKET_PEAK_DETECTOR_SUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q     <= '0;
            out_sum_q <= '0;
        end else begin
            sum_q     <= sum_d;
            out_sum_q <= out_sum_d;
        end
    end

    assign source_sum = out_sum_q;
`else
    assign source_sum = '0;
`endif

    assign source_valid  = out_vld_q;
    assign source_max    = out_max_q;
    assign source_argmax = out_argmax_q;
    assign source_error  = out_err_q;

endmodule
